// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and small decode helpers for access size and alignment.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_byte(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == LDST_H) || (size == LDST_HU);
  endfunction

  // Codes 3, 6 and 7 fall through to word accesses.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    if (is_byte(size)) begin
      return 1'b0;
    end else if (is_half(size)) begin
      return off[0];
    end else begin
      return (off != 2'b00);
    end
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
// slave is the LSU view; master is the view of the core plus memory environment.
interface lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load data reduction: picks byte/half/word from a memory word
// at the given byte offset and sign- or zero-extends it.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  // Extension selected by funct3 size code.
  always_comb begin
    o_data = i_word;
    case (i_size)
      LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LDST_BU: o_data = {24'd0, w_byte};
      LDST_H:  o_data = {{16{w_half[15]}}, w_half};
      LDST_HU: o_data = {16'd0, w_half};
      LDST_W:  o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with IDLE/WAIT/DONE handshake FSM.
// Optional build macro LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  lsu_if.slave   bus,
  output logic   misaligned_o
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [31:0] r_word;
  logic [1:0]  r_off;
  logic        r_mis;
  logic        w_mem_req;
  logic        w_stall;
  logic        w_mis;
  logic [31:0] w_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_mis = is_misaligned(bus.core_size_i, bus.core_addr_i[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // Next-state and handshake decode.
  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_stall   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.core_req_i) begin
          w_stall = 1'b1;
          if (w_mis) begin
            w_next = DONE;
          end else begin
            w_mem_req = 1'b1;
            w_next    = bus.mem_ready_i ? DONE : WAIT;
          end
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        w_mem_req = 1'b1;
        w_stall   = 1'b1;
        w_next    = bus.mem_ready_i ? DONE : WAIT;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture read word and byte offset on the completing memory cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word <= 32'd0;
      r_off  <= 2'd0;
      r_mis  <= 1'b0;
    end else begin
      if (w_mem_req && bus.mem_ready_i) begin
        r_word <= bus.mem_rd_i;
        r_off  <= bus.core_addr_i[1:0];
      end
      r_mis <= (r_state == IDLE) && bus.core_req_i && w_mis;
    end
  end

  // Store byte lanes and replicated write data.
  always_comb begin
    bus.mem_be_o = 4'b1111;
    bus.mem_wd_o = bus.core_wd_i;
    if (is_byte(bus.core_size_i)) begin
      bus.mem_wd_o = {4{bus.core_wd_i[7:0]}};
      bus.mem_be_o = bus.core_we_i ? (4'b0001 << bus.core_addr_i[1:0]) : 4'b1111;
    end else if (is_half(bus.core_size_i)) begin
      bus.mem_wd_o = {2{bus.core_wd_i[15:0]}};
      bus.mem_be_o = bus.core_we_i ? (bus.core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end else begin
      bus.mem_wd_o = bus.core_wd_i;
      bus.mem_be_o = 4'b1111;
    end
  end

  lsu_load_extend u_load_extend (
    .i_word (r_word),
    .i_off  (r_off),
    .i_size (bus.core_size_i),
    .o_data (w_ext)
  );

  assign bus.mem_req_o    = w_mem_req & ~rst_i;
  assign bus.core_stall_o = w_stall & ~rst_i;
  assign bus.mem_we_o     = bus.core_we_i & w_mem_req & ~rst_i;
  assign bus.mem_addr_o   = {bus.core_addr_i[31:2], 2'b00};
  assign bus.core_rd_o    = ((r_state == DONE) && !bus.core_we_i && !r_mis && !rst_i) ? w_ext : 32'd0;
  assign misaligned_o     = (r_state == DONE) && r_mis && !rst_i;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected load results go through a
// scoreboard queue and are compared when the unit reaches DONE.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  logic mis;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

  lsu_if bus();

  load_store_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .misaligned_o (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access; waits = cycles mem_ready_i stays low before completing.
  task automatic do_access(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdw, input int waits,
                           input logic [31:0] exp_rd, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic exp_mis);
    int   n_stall;
    bit   done;
    logic req_any;
    logic req_all;
    logic [31:0] exp_v;
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
    bus.mem_rd_i    = rdw;
    bus.mem_ready_i = (waits == 0);
    n_stall = 0;
    done    = 1'b0;
    req_any = 1'b0;
    req_all = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.core_stall_o) begin
        if (n_stall == 0 && !exp_mis) begin
          chk({tag, "_addr"}, bus.mem_addr_o, exp_addr);
          chk({tag, "_be"}, {28'd0, bus.mem_be_o}, {28'd0, exp_be});
          chk({tag, "_we"}, {31'd0, bus.mem_we_o}, {31'd0, we});
          if (we) chk({tag, "_wd"}, bus.mem_wd_o, exp_wd);
        end
        n_stall++;
        req_any = req_any | bus.mem_req_o;
        req_all = req_all & bus.mem_req_o;
        @(posedge clk); #1;
        bus.mem_ready_i = (n_stall == waits);
      end else begin
        done = 1'b1;
      end
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_sb_nonempty"}, exp_q.size(), 32'd1);
    exp_v = exp_q.pop_front();
    chk({tag, "_rd"}, bus.core_rd_o, exp_v);
    chk({tag, "_mis"}, {31'd0, mis}, {31'd0, exp_mis});
    chk({tag, "_donereq"}, {31'd0, bus.mem_req_o}, 32'd0);
    if (exp_mis) begin
      chk({tag, "_stalls"}, n_stall, 32'd1);
      chk({tag, "_noreq"}, {31'd0, req_any}, 32'd0);
    end else begin
      chk({tag, "_stalls"}, n_stall, waits + 1);
      chk({tag, "_reqall"}, {31'd0, req_all}, 32'd1);
    end
    @(posedge clk); #1;
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    chk({tag, "_rd_after"}, bus.core_rd_o, 32'd0);
    chk({tag, "_stall_after"}, {31'd0, bus.core_stall_o}, 32'd0);
    chk({tag, "_mis_after"}, {31'd0, mis}, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = LDST_W;
    bus.core_addr_i = 32'h0000_0000;
    bus.core_wd_i   = 32'h0000_0000;
    bus.mem_rd_i    = 32'hFFFF_FFFF;
    bus.mem_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.core_stall_o}, 32'd0);
    chk("rst_rd", bus.core_rd_o, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    @(posedge clk); #1;
    rst             = 1'b0;
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("idle_stall", {31'd0, bus.core_stall_o}, 32'd0);

    do_access("lb",  1'b0, LDST_B,  32'h103, 32'h0, 32'h80FF1234, 2, 32'hFFFFFF80, 32'h100, 4'b1111, 32'h0, 1'b0);
    do_access("lbu", 1'b0, LDST_BU, 32'h103, 32'h0, 32'h80FF1234, 2, 32'h00000080, 32'h100, 4'b1111, 32'h0, 1'b0);
    do_access("lh",  1'b0, LDST_H,  32'h002, 32'h0, 32'hBEEF0000, 0, 32'hFFFFBEEF, 32'h000, 4'b1111, 32'h0, 1'b0);
    do_access("lhu", 1'b0, LDST_HU, 32'h002, 32'h0, 32'hBEEF0000, 0, 32'h0000BEEF, 32'h000, 4'b1111, 32'h0, 1'b0);
    do_access("sh",  1'b1, LDST_H,  32'h202, 32'h0000ABCD, 32'h55AA55AA, 0, 32'h0, 32'h200, 4'b1100, 32'hABCDABCD, 1'b0);
    do_access("sb",  1'b1, LDST_B,  32'h001, 32'h12345677, 32'h55AA55AA, 1, 32'h0, 32'h000, 4'b0010, 32'h77777777, 1'b0);
    do_access("sw",  1'b1, LDST_W,  32'h300, 32'hDEADBEEF, 32'h0, 0, 32'h0, 32'h300, 4'b1111, 32'hDEADBEEF, 1'b0);
    do_access("sh_lo", 1'b1, LDST_H, 32'h040, 32'h99991357, 32'h0, 0, 32'h0, 32'h040, 4'b0011, 32'h13571357, 1'b0);
    do_access("lw",  1'b0, LDST_W,  32'h008, 32'h0, 32'h12345678, 1, 32'h12345678, 32'h008, 4'b1111, 32'h0, 1'b0);
    do_access("sz3", 1'b0, 3'd3,    32'h010, 32'h0, 32'h8765_4321, 0, 32'h87654321, 32'h010, 4'b1111, 32'h0, 1'b0);
    do_access("lb_pos", 1'b0, LDST_B, 32'h021, 32'h0, 32'h00007F00, 0, 32'h0000007F, 32'h020, 4'b1111, 32'h0, 1'b0);
    do_access("lh_neg", 1'b0, LDST_H, 32'h030, 32'h0, 32'h00008001, 3, 32'hFFFF8001, 32'h030, 4'b1111, 32'h0, 1'b0);

    // Reset while waiting on memory abandons the access.
    @(posedge clk); #1;
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = LDST_W;
    bus.core_addr_i = 32'h400;
    bus.mem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_req", {31'd0, bus.mem_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rstw_stall", {31'd0, bus.core_stall_o}, 32'd0);
    @(posedge clk); #1;
    rst            = 1'b0;
    bus.core_req_i = 1'b0;
    @(negedge clk);
    chk("postrst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("postrst_stall", {31'd0, bus.core_stall_o}, 32'd0);
    chk("postrst_rd", bus.core_rd_o, 32'd0);
    @(negedge clk);
    chk("postrst_req2", {31'd0, bus.mem_req_o}, 32'd0);

`ifdef LSU_MISALIGN_CHECK_EN
    do_access("lw_mis", 1'b0, LDST_W, 32'h006, 32'h0, 32'hCAFEF00D, 0, 32'h0, 32'h004, 4'b1111, 32'h0, 1'b1);
    do_access("sh_mis", 1'b1, LDST_H, 32'h203, 32'h1234, 32'h0, 0, 32'h0, 32'h200, 4'b1100, 32'h12341234, 1'b1);
`else
    do_access("lw_mis", 1'b0, LDST_W, 32'h006, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 32'h004, 4'b1111, 32'h0, 1'b0);
    do_access("lh_mis", 1'b0, LDST_H, 32'h003, 32'h0, 32'h8000_1111, 0, 32'hFFFF8000, 32'h000, 4'b1111, 32'h0, 1'b0);
`endif

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
